// File: rtl/fifo_pkg.sv
// Shared defaults and helper types for the synchronous FIFO slice.
package fifo_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned ADDR_W_DEF   = 4;
  localparam int unsigned AF_LEVEL_DEF = 12;
  localparam int unsigned AE_LEVEL_DEF = 4;

  // Encoding is {read, write} so an accepted-request pair casts directly.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e op_of(input logic wr_acc, input logic rd_acc);
    return fifo_op_e'({rd_acc, wr_acc});
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage: one write port, one synchronous read port, no reset.
module fifo_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Same-address read and write return the old word (needed when full).
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, threshold flags and sticky errors.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned AF_LEVEL = AF_LEVEL_DEF,
  parameter int unsigned AE_LEVEL = AE_LEVEL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

  logic [ADDR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, empty_q, af_q, ae_q;
  logic              ovf_q, udf_q, rd_valid_q;
  logic [DATA_W-1:0] hold_q, ram_rdata;
  logic              rd_acc, wr_acc, ovf_evt, udf_evt;
  fifo_op_e          op;

  always_comb begin
    rd_acc  = cs & rd_en & ~empty_q;
    wr_acc  = cs & wr_en & (~full_q | rd_acc);
    ovf_evt = cs & wr_en & full_q & ~rd_acc;
    udf_evt = cs & rd_en & empty_q;
    op      = op_of(wr_acc, rd_acc);
    head_d  = rd_acc ? head_q + ADDR_W'(1) : head_q;
    tail_d  = wr_acc ? tail_q + ADDR_W'(1) : tail_q;
    count_d = count_q;
    case (op)
      OP_PUSH: count_d = count_q + (ADDR_W+1)'(1);
      OP_POP:  count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      full_q     <= (count_d == DEPTH_C);
      empty_q    <= (count_d == '0);
      af_q       <= (count_d >= AF_C);
      ae_q       <= (count_d <= AE_C);
      ovf_q      <= ovf_q | ovf_evt;
      udf_q      <= udf_q | udf_evt;
      rd_valid_q <= rd_acc;
      if (rd_valid_q) hold_q <= ram_rdata;
    end
  end

  // RAM output has no reset; hold_q gives the reset-to-zero and hold behaviour.
  fifo_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc & ~rst),
    .waddr(tail_q),
    .wdata(wr_data),
    .re   (rd_acc & ~rst),
    .raddr(head_q),
    .rdata(ram_rdata)
  );

  assign rd_data      = rd_valid_q ? ram_rdata : hold_q;
  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed plus random stimulus for sync_fifo against a queue-based reference.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst, cs, wr_en, rd_en;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  logic [7:0] q[$];
  logic [7:0] m_rd_data;
  logic       m_rd_valid, m_ovf, m_udf;

  always #5 clk = ~clk;

  sync_fifo #(
    .DATA_W(8),
    .ADDR_W(4),
    .AF_LEVEL(12),
    .AE_LEVEL(4)
  ) dut (
    .clk(clk), .rst(rst), .cs(cs), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int unsigned n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == 16));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= 12));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 4));
    chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
    chk("rd_data", 32'(rd_data), 32'(m_rd_data));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
  endtask

  task automatic model(input logic r, input logic c, input logic w, input logic rd, input logic [7:0] d);
    bit rd_ok, wr_ok;
    if (r) begin
      q.delete();
      m_rd_data = '0; m_rd_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      return;
    end
    m_rd_valid = 1'b0;
    if (!c) return;
    rd_ok = rd && (q.size() > 0);
    wr_ok = w && (q.size() < 16 || rd_ok);
    if (w && q.size() == 16 && !rd_ok) m_ovf = 1'b1;
    if (rd && q.size() == 0) m_udf = 1'b1;
    if (rd_ok) begin
      m_rd_data = q.pop_front();
      m_rd_valid = 1'b1;
    end
    if (wr_ok) q.push_back(d);
  endtask

  task automatic step(input logic r, input logic c, input logic w, input logic rd, input logic [7:0] d);
    rst = r; cs = c; wr_en = w; rd_en = rd; wr_data = d;
    @(posedge clk);
    #1;
    model(r, c, w, rd, d);
    check_all();
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    q.delete(); m_rd_data = '0; m_rd_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    @(negedge clk);

    // Reset, fill 0x01..0x10, drain in order
    step(1, 0, 0, 0, 8'h00);
    for (int i = 1; i <= 16; i++) step(0, 1, 1, 0, 8'(i));
    for (int i = 0; i < 16; i++) step(0, 1, 0, 1, 8'h00);
    step(0, 1, 0, 0, 8'h00);

    // Overflow on full FIFO, then drain
    for (int i = 0; i < 16; i++) step(0, 1, 1, 0, 8'(8'h20 + i));
    step(0, 1, 1, 0, 8'hAA);
    step(0, 1, 1, 0, 8'hAA);
    for (int i = 0; i < 17; i++) step(0, 1, 0, 1, 8'h00);

    // Underflow on empty, then simultaneous read/write when empty
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 1, 8'h00);
    step(0, 1, 1, 1, 8'h55);
    step(0, 1, 0, 1, 8'h00);
    step(0, 1, 0, 0, 8'h00);

    // Full FIFO with 20 cycles of simultaneous read/write
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) step(0, 1, 1, 0, 8'(8'h40 + i));
    for (int i = 0; i < 20; i++) step(0, 1, 1, 1, (i == 0) ? 8'h77 : 8'(8'h80 + i));
    for (int i = 0; i < 16; i++) step(0, 1, 0, 1, 8'h00);

    // Reset mid-stream with a write pending, then chip-select gating
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 8'(8'hC0 + i));
    step(1, 1, 1, 0, 8'hEE);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 8'(8'hD0 + i));
    step(0, 1, 0, 1, 8'h00);
    step(0, 0, 1, 1, 8'h99);
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 1, 0, 8'h98);

    // Randomized traffic with occasional reset and chip-select drops
    for (int i = 0; i < 2000; i++) begin
      logic r, c, w, rd;
      int unsigned bias;
      bias = (i / 250) % 3;
      r  = ($urandom_range(0, 199) == 0);
      c  = ($urandom_range(0, 9) != 0);
      w  = ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)));
      rd = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)));
      step(r, c, w, rd, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
